// File: rtl/u_iex_pipe_ctrl.sv
// IEX stage sequencing: ALU pipe gating, one-entry result stage to LSU/WB,
// and the redirect/flush FSM that steers the front end after a taken BRU flush.
module u_iex_pipe_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int PC_WIDTH     = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idu_iex_vld,
  output logic                  iex_idu_rdy,
  output logic                  iex_alu_pipe_vld,
  input  logic                  alu_iex_bru_vld,
  input  logic                  alu_iex_bru_flush,
  input  logic [PC_WIDTH-1:0]   alu_iex_bru_redir_pc,
  input  logic [DATA_WIDTH-1:0] alu_iex_cal_data,
  output logic                  iex_ifu_redir_vld,
  output logic [PC_WIDTH-1:0]   iex_ifu_redir_pc,
  input  logic                  ifu_iex_redir_rdy,
  output logic                  iex_flush_front,
  output logic                  iex_lsu_vld,
  output logic [DATA_WIDTH-1:0] iex_lsu_data,
  input  logic                  lsu_iex_rdy,
  output logic [31:0]           iex_retire_cnt
);

  // state    | meaning
  // ST_RUN   | normal issue; accepted beats are written and retired
  // ST_REDIR | redirect offered to IFU, front end killed, beats discarded
  // ST_DRAIN | in-flight wrong-path beats still arriving, discarded
  typedef enum logic [1:0] {ST_RUN, ST_REDIR, ST_DRAIN} state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  lsu_vld_q, lsu_vld_d;
  logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;
  logic                  redir_vld_q, redir_vld_d;
  logic [PC_WIDTH-1:0]   redir_pc_q, redir_pc_d;
  logic [31:0]           retire_cnt_q, retire_cnt_d;
  logic                  acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      lsu_vld_q    <= 1'b0;
      lsu_data_q   <= '0;
      redir_vld_q  <= 1'b0;
      redir_pc_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lsu_vld_q    <= lsu_vld_d;
      lsu_data_q   <= lsu_data_d;
      redir_vld_q  <= redir_vld_d;
      redir_pc_q   <= redir_pc_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    redir_vld_d = redir_vld_q;
    redir_pc_d  = redir_pc_q;
    case (state_q)
      ST_RUN: begin
        if (acc && alu_iex_bru_vld && alu_iex_bru_flush) begin
          redir_pc_d  = alu_iex_bru_redir_pc;
          redir_vld_d = 1'b1;
          state_d     = ST_REDIR;
        end
      end
      ST_REDIR: begin
        if (ifu_iex_redir_rdy) begin
          redir_vld_d = 1'b0;
          cnt_d       = DRAIN_INIT;
          state_d     = (DRAIN_INIT == 4'd0) ? ST_RUN : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Only RUN-state acceptances reach the output stage; REDIR/DRAIN swallow beats.
  always_comb begin
    iex_idu_rdy      = 1'b1;
    iex_alu_pipe_vld = 1'b0;
    iex_flush_front  = 1'b0;
    if (state_q == ST_RUN) begin
      iex_idu_rdy      = ~lsu_vld_q | lsu_iex_rdy;
      iex_alu_pipe_vld = idu_iex_vld;
    end
    if (state_q == ST_REDIR) iex_flush_front = 1'b1;
    acc = (state_q == ST_RUN) & idu_iex_vld & iex_idu_rdy;
  end

  always_comb begin
    lsu_vld_d    = lsu_vld_q;
    lsu_data_d   = lsu_data_q;
    retire_cnt_d = retire_cnt_q;
    if (acc) begin
      lsu_vld_d    = 1'b1;
      lsu_data_d   = alu_iex_cal_data;
      retire_cnt_d = retire_cnt_q + 32'd1;
    end else if (lsu_iex_rdy) begin
      lsu_vld_d = 1'b0;
    end
  end

  assign iex_ifu_redir_vld = redir_vld_q;
  assign iex_ifu_redir_pc  = redir_pc_q;
  assign iex_lsu_vld       = lsu_vld_q;
  assign iex_lsu_data      = lsu_data_q;
  assign iex_retire_cnt    = retire_cnt_q;

endmodule
